// File: rtl/rca_nibble_add_seq.sv
// rca_nibble_add_seq: nibble-serial 32-bit add/subtract sequencer reusing one 4-bit ripple-carry slice

module bit4_RCA (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [4:0] c;
    assign c[0] = cin_i;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[4];
endmodule

module rca_nibble_add_seq #(
    parameter int NIBBLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic [CW-1:0]   cnt_q;
    logic            c_q, cout_q, ovf_q;
    logic [3:0]      s;
    logic            co, last;

    assign last      = cnt_q == CW'(NIBBLES - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    bit4_RCA u_slice (
        .a_i    (a_q[4*cnt_q +: 4]),
        .b_i    (b_q[4*cnt_q +: 4]),
        .cin_i  (c_q),
        .s_o    (s),
        .cout_o (co)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // accept in IDLE, step through nibbles in RUN, hold result in DONE until taken
    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE ? (in_valid ? RUN : IDLE) :
                  state_q == RUN  ? (last ? DONE : RUN) :
                                    (out_ready ? IDLE : DONE);
    end

    // operand latch on accept, one nibble of sum and the carry chain per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            a_q   <= a;
            b_q   <= op_sub ? ~b : b;
            c_q   <= op_sub ? 1'b1 : cin;
            cnt_q <= '0;
            sum_q <= '0;
        end else if (state_q == RUN) begin
            sum_q[4*cnt_q +: 4] <= s;
            c_q                 <= co;
            cnt_q               <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= co;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (s[3] != a_q[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_rca_nibble_add_seq.sv
// tb_rca_nibble_add_seq: directed and streaming checks of the nibble-serial adder
`timescale 1ns/1ps
module tb_rca_nibble_add_seq;
    logic        clk = 0, rst = 1, in_valid = 0, cin = 0, op_sub = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, cout, ovf, busy;
    logic [31:0] sum;
    int          pass = 0, total = 0;

    rca_nibble_add_seq #(.NIBBLES(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue one op from IDLE, wait (bounded) for out_valid, return result, then take it
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic sb, output logic [31:0] s, output logic co,
                          output logic ov, output int lat);
        a = av; b = bv; cin = ci; op_sub = sb; in_valid = 1;
        tick();
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        s = sum; co = cout; ov = ovf;
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
        total++; if ({sum, cout, ovf} !== 34'h0) $display("FAIL reset_outputs got %h/%b/%b want 0/0/0", sum, cout, ovf); else pass++;
        rst = 0;
        tick();
    endtask

    task automatic test_add();
        logic [31:0] s; logic co, ov; int lat;
        run_op(32'hFFFFFFFF, 32'h00000001, 0, 0, s, co, ov, lat);
        total++; if (lat !== 8) $display("FAIL add_latency got %0d want 8", lat); else pass++;
        total++; if ({s, co, ov} !== {32'h00000000, 1'b1, 1'b0}) $display("FAIL add_wrap got %h/%b/%b want 00000000/1/0", s, co, ov); else pass++;
        run_op(32'h7FFFFFFF, 32'h00000001, 0, 0, s, co, ov, lat);
        total++; if ({s, co, ov} !== {32'h80000000, 1'b0, 1'b1}) $display("FAIL add_ovf got %h/%b/%b want 80000000/0/1", s, co, ov); else pass++;
        run_op(32'h0, 32'h0, 1, 0, s, co, ov, lat);
        total++; if ({s, co, ov} !== {32'h00000001, 1'b0, 1'b0}) $display("FAIL add_cin got %h/%b/%b want 00000001/0/0", s, co, ov); else pass++;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL add_idle got rdy=%b busy=%b want 1/0", in_ready, busy); else pass++;
    endtask

    task automatic test_sub();
        logic [31:0] s; logic co, ov; int lat;
        run_op(32'h00000005, 32'h00000007, 1, 1, s, co, ov, lat);
        total++; if ({s, co, ov} !== {32'hFFFFFFFE, 1'b0, 1'b0}) $display("FAIL sub_borrow got %h/%b/%b want FFFFFFFE/0/0", s, co, ov); else pass++;
        run_op(32'h80000000, 32'h00000001, 0, 1, s, co, ov, lat);
        total++; if ({s, co, ov} !== {32'h7FFFFFFF, 1'b1, 1'b1}) $display("FAIL sub_ovf got %h/%b/%b want 7FFFFFFF/1/1", s, co, ov); else pass++;
    endtask

    task automatic test_backpressure();
        int lat = 0;
        a = 32'h0000000A; b = 32'h00000003; cin = 0; op_sub = 1; in_valid = 1;
        tick();
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        total++; if (lat !== 8) $display("FAIL bp_latency got %0d want 8", lat); else pass++;
        a = 32'h11111111; b = 32'h22222222; op_sub = 0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || {sum, cout, ovf} !== {32'h00000007, 1'b1, 1'b0})
                $display("FAIL bp_hold%0d got v=%b rdy=%b busy=%b %h/%b/%b want 1/0/1 00000007/1/0",
                         i, out_valid, in_ready, busy, sum, cout, ovf);
            else pass++;
            tick();
        end
        out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy); else pass++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL bp_no_accept got busy=%b want 0", busy); else pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] s; logic co, ov; int lat; int seen = 0;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1; op_sub = 0; in_valid = 1;
        tick();
        in_valid = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== 32'h0) $display("FAIL rst_mid got v=%b rdy=%b busy=%b sum=%h want 0/1/0/0", out_valid, in_ready, busy, sum); else pass++;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        total++; if (seen !== 0) $display("FAIL rst_no_pulse got %0d valid cycles want 0", seen); else pass++;
        run_op(32'h12345678, 32'h11111111, 0, 0, s, co, ov, lat);
        total++; if ({s, co} !== {32'h23456789, 1'b0}) $display("FAIL rst_after_op got %h/%b want 23456789/0", s, co); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        logic        expo_q[$];
        logic [32:0] r;
        logic [31:0] ra, rb;
        logic        rc, rs, ro;
        int          nacc = 0, nres = 0, last_acc = 0;
        in_valid = 1; out_ready = 1;
        for (int cyc = 0; cyc < 400 && nres < 20; cyc++) begin
            if (out_valid) begin
                total++;
                if ({cout, sum, ovf} !== {exp_q[0], expo_q[0]})
                    $display("FAIL b2b_result%0d got %b/%h/%b want %b/%h/%b", nres, cout, sum, ovf, exp_q[0][32], exp_q[0][31:0], expo_q[0]);
                else pass++;
                void'(exp_q.pop_front());
                void'(expo_q.pop_front());
                nres++;
            end
            if (in_ready && nacc < 20) begin
                ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                if (nacc % 5 == 1) ra = 32'h7FFFFFFF;
                a = ra; b = rb; cin = rc; op_sub = rs;
                r  = rs ? {1'b0, ra} - {1'b0, rb} + 33'h100000000 : {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
                ro = rs ? (ra[31] != rb[31] && r[31] != ra[31]) : (ra[31] == rb[31] && r[31] != ra[31]);
                exp_q.push_back(r);
                expo_q.push_back(ro);
                if (nacc > 0) begin
                    total++;
                    if (cyc - last_acc !== 10) $display("FAIL b2b_spacing%0d got %0d want 10", nacc, cyc - last_acc); else pass++;
                end
                last_acc = cyc;
                nacc++;
            end else if (in_ready) in_valid = 0;
            tick();
        end
        total++; if (nres !== 20) $display("FAIL b2b_count got %0d results want 20", nres); else pass++;
        in_valid = 0; out_ready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
